// File: rtl/keypad_scan_ctrl.sv
// Row-scan sequencer and press/release debouncer for a 4x4 hex keypad.
// Each debounced press is offered once to the consumer over a valid/ready handshake.
module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 24000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] col_i,
  input  logic       key_ready_i,
  output logic [3:0] row_o,
  output logic       key_valid_o,
  output logic [3:0] key_code_o,
  output logic       key_held_o,
  output logic       overrun_o
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_RELEASE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic          held_q, held_d;
  logic          overrun_q, overrun_d;

  logic          one_low;
  logic [1:0]    low_idx;
  logic          col_bit;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Multiple low columns on one row are ghosting/ambiguous and are skipped.
  assign one_low = ($countones(~col_i) == 1);

  always_comb begin
    low_idx = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (!col_i[j]) low_idx = 2'(j);
    end
  end

  // Only the captured column is watched once a key is being debounced.
  assign col_bit = col_i[col_q];

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    valid_d    = valid_q;
    code_d     = code_q;
    held_d     = held_q;
    overrun_d  = 1'b0;

    if (valid_q && key_ready_i) valid_d = 1'b0;

    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (one_low) begin
            col_d    = low_idx;
            db_cnt_d = '0;
            state_d  = DB_PRESS;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      DB_PRESS: begin
        if (col_bit) begin
          db_cnt_d = '0;
          row_d    = row_q + 2'd1;
          state_d  = SCAN;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = HELD;
          held_d  = 1'b1;
          // A key accepted on this same edge frees the slot for the new one.
          if (!valid_q || key_ready_i) begin
            code_d  = key_map(row_q, col_q);
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      HELD: begin
        if (col_bit) begin
          db_cnt_d = '0;
          state_d  = DB_RELEASE;
        end
      end

      DB_RELEASE: begin
        if (!col_bit) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          held_d   = 1'b0;
          db_cnt_d = '0;
          row_d    = row_q + 2'd1;
          state_d  = SCAN;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= SCAN;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      scan_cnt_q <= '0;
      db_cnt_q   <= '0;
      valid_q    <= 1'b0;
      code_q     <= 4'h0;
      held_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      db_cnt_q   <= db_cnt_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      held_q     <= held_d;
      overrun_q  <= overrun_d;
    end
  end

  assign row_o       = ~(4'b0001 << row_q);
  assign key_valid_o = valid_q;
  assign key_code_o  = code_q;
  assign key_held_o  = held_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives the columns from the
// row outputs; expected key codes are queued at press time and matched on accept.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] col;
  logic       key_ready;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic       overrun;

  logic [3:0][3:0] pressed;  // [row][col]
  logic [3:0]      exp_q[$];
  int              n_chk  = 0;
  int              n_pass = 0;
  int              vld_cyc = 0;
  int              vld_base;

  keypad_scan_ctrl #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk_i(clk), .reset_i(reset), .col_i(col), .key_ready_i(key_ready),
    .row_o(row), .key_valid_o(key_valid), .key_code_o(key_code),
    .key_held_o(key_held), .overrun_o(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (!row[i] && pressed[i][j]) col[j] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset && key_valid) begin
      vld_cyc++;
      if (key_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_row_fresh(input logic [3:0] r);
    logic [3:0] prev;
    int n;
    prev = row;
    n = 0;
    do begin
      tick();
      n++;
      if (row == r && prev != r) return;
      prev = row;
    end while (n < 64);
    chk("row_sync_timeout", 32'(row), 32'(r));
  endtask

  task automatic wait_held(input logic lvl, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (key_held != lvl && n < 64);
    chk(tag, 32'(key_held), 32'(lvl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] rseq [4];
    rseq[0] = 4'b1101; rseq[1] = 4'b1011; rseq[2] = 4'b0111; rseq[3] = 4'b1110;
    reset = 1'b1;
    key_ready = 1'b0;
    pressed = '0;

    // Reset and idle row rotation
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_row", 32'(row), 32'h0E);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    for (int k = 0; k < 4; k++) begin
      repeat (4) tick();
      chk("rotate_row", 32'(row), 32'(rseq[k]));
    end

    // Clean press r1c2 -> 6, fixed latency, release timing
    key_ready = 1'b1;
    wait_row_fresh(4'b1101);
    pressed[1][2] = 1'b1;
    exp_q.push_back(4'h6);
    repeat (11) tick();
    chk("press_early_valid", 32'(key_valid), 32'd0);
    chk("press_early_held", 32'(key_held), 32'd0);
    chk("press_row_frozen", 32'(row), 32'h0D);
    tick();
    chk("press_valid", 32'(key_valid), 32'd1);
    chk("press_held", 32'(key_held), 32'd1);
    chk("press_code", 32'(key_code), 32'h6);
    tick();
    chk("press_valid_drop", 32'(key_valid), 32'd0);
    repeat (17) tick();
    pressed[1][2] = 1'b0;
    repeat (8) tick();
    chk("release_held_still", 32'(key_held), 32'd1);
    tick();
    chk("release_held_drop", 32'(key_held), 32'd0);
    chk("release_next_row", 32'(row), 32'h0B);
    chk("press_one_pulse", 32'(vld_cyc), 32'd1);

    // Bounce on r0c0: 4 DB_PRESS cycles low, then high
    vld_base = vld_cyc;
    wait_row_fresh(4'b1110);
    pressed[0][0] = 1'b1;
    repeat (5) tick();
    chk("bounce_row_frozen", 32'(row), 32'h0E);
    repeat (2) tick();
    pressed[0][0] = 1'b0;
    chk("bounce_held", 32'(key_held), 32'd0);
    tick();
    chk("bounce_next_row", 32'(row), 32'h0D);
    repeat (4) tick();
    chk("bounce_no_valid", 32'(vld_cyc - vld_base), 32'd0);

    // Backpressure and overrun
    key_ready = 1'b0;
    pressed[3][1] = 1'b1;
    exp_q.push_back(4'h0);
    wait_held(1'b1, "bp_held1");
    chk("bp_valid", 32'(key_valid), 32'd1);
    chk("bp_code", 32'(key_code), 32'h0);
    pressed[3][1] = 1'b0;
    wait_held(1'b0, "bp_release1");
    chk("bp_overrun_idle", 32'(overrun), 32'd0);
    pressed[0][3] = 1'b1;
    wait_held(1'b1, "bp_held2");
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_code_kept", 32'(key_code), 32'h0);
    chk("bp_valid_kept", 32'(key_valid), 32'd1);
    tick();
    chk("bp_overrun_pulse", 32'(overrun), 32'd0);
    key_ready = 1'b1;
    tick();
    chk("bp_accept_clear", 32'(key_valid), 32'd0);
    pressed[0][3] = 1'b0;
    wait_held(1'b0, "bp_release2");

    // Ghost: two columns low on r2
    vld_base = vld_cyc;
    pressed[2][0] = 1'b1;
    pressed[2][1] = 1'b1;
    wait_row_fresh(4'b1011);
    repeat (4) tick();
    chk("ghost_rotate", 32'(row), 32'h07);
    chk("ghost_held", 32'(key_held), 32'd0);
    repeat (12) tick();
    chk("ghost_rotate2", 32'(row), 32'h0B);
    repeat (4) tick();
    chk("ghost_no_valid", 32'(vld_cyc - vld_base), 32'd0);
    pressed = '0;

    // Reset during DB_PRESS on r0c1
    wait_row_fresh(4'b1110);
    pressed[0][1] = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    pressed = '0;
    tick();
    reset = 1'b0;
    vld_base = vld_cyc;
    chk("mid_rst_row", 32'(row), 32'h0E);
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_held", 32'(key_held), 32'd0);
    repeat (4) tick();
    chk("mid_rst_scan", 32'(row), 32'h0D);
    repeat (20) tick();
    chk("mid_rst_no_valid", 32'(vld_cyc - vld_base), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
